// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, PC increment, NOP encoding and the
// fetch-queue entry layout used between the fetch buffer and its storage.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Storage array for the fetch queue: one synchronous write port and one
// asynchronous read port. Entry validity is tracked by the owner's count.
module fetch_fifo_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t r_mem [DEPTH];

  // NOTE: the data array is deliberately not reset; stale contents are never
  // observed because the owner gates every read with its occupancy count.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between the PC register and ID: queues {pc+4, instr}
// pairs, gates the PC enable on room, and drops wrong-path entries on flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            pc_enable_o,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [AW:0]     count_o
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_enq;
  logic          w_deq;
  logic [AW:0]   w_count_nxt;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // Fullness alone decides fetch; keeping stall_i out of this cone is what
  // costs one bubble after the queue fills.
  assign pc_enable_o = ~w_full | flush_i;

  assign w_enq = start_i & ~w_full & ~flush_i;
  assign w_deq = ~w_empty & ~stall_i;

  assign w_wdata.pc4   = pc_i + PC_STEP;
  assign w_wdata.instr = instr_i;

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_enq),
    .waddr_i (r_wr_ptr),
    .wdata_i (w_wdata),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_head)
  );

  // NOTE: every signal driven in always_comb gets a default first so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    id_valid_o = 1'b0;
    id_pc4_o   = '0;
    id_instr_o = NOP_INSTR;
    if (!w_empty) begin
      id_valid_o = 1'b1;
      id_pc4_o   = w_head.pc4;
      id_instr_o = w_head.instr;
    end
  end

  assign count_o = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model predicts head, count and PC
// enable every cycle while directed sequences exercise fill, stall, flush and reset.
`timescale 1ns/1ps
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] instr_i;
  logic            stall_i;
  logic            flush_i;
  logic            pc_enable_o;
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc4_o;
  logic [XLEN-1:0] id_instr_o;
  logic [AW:0]     count_o;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pc_enable_o (pc_enable_o),
    .id_valid_o  (id_valid_o),
    .id_pc4_o    (id_pc4_o),
    .id_instr_o  (id_instr_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  fetch_entry_t    sb[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [XLEN-1:0] pc;
  logic            max_cnt_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, compare the settled
  // outputs to the model, update the model, then advance to the next falling edge.
  task automatic step(input logic start, input logic stall, input logic flush,
                      input logic [XLEN-1:0] instr, input logic [XLEN-1:0] target);
    logic exp_en, enq, deq;
    fetch_entry_t e;
    start_i = start; stall_i = stall; flush_i = flush; pc_i = pc; instr_i = instr;
    #1;
    exp_en = (sb.size() < DEPTH) || flush;
    check("count", 64'(count_o), 64'(sb.size()));
    check("pc_en", 64'(pc_enable_o), 64'(exp_en));
    check("valid", 64'(id_valid_o), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("pc4",   64'(id_pc4_o),   64'(sb[0].pc4));
      check("instr", 64'(id_instr_o), 64'(sb[0].instr));
    end else begin
      check("pc4_empty",   64'(id_pc4_o),   64'h0);
      check("instr_empty", 64'(id_instr_o), 64'(NOP_INSTR));
    end
    if (sb.size() == DEPTH) max_cnt_seen = 1'b1;
    enq = start && (sb.size() < DEPTH) && !flush;
    deq = (sb.size() != 0) && !stall;
    if (flush) begin
      sb.delete();
      pc = target;
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) begin
        e.pc4 = pc + 32'd4;
        e.instr = instr;
        sb.push_back(e);
      end
      if (start && exp_en) pc = pc + 32'd4;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    pc_i = '0; instr_i = '0; pc = '0; max_cnt_seen = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_count", 64'(count_o), 64'h0);
    check("rst_valid", 64'(id_valid_o), 64'h0);
    check("rst_instr", 64'(id_instr_o), 64'h0);
    check("rst_pc4",   64'(id_pc4_o), 64'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Streaming with no stalls: A,B,C flow through at occupancy 1.
    step(1, 0, 0, 32'hAAAA_0001, 0);
    step(1, 0, 0, 32'hBBBB_0002, 0);
    step(1, 0, 0, 32'hCCCC_0003, 0);
    check("stream_count", 64'(count_o), 64'h1);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);

    // Stall for four cycles: fills, PC enable drops, head holds; then drain in order.
    for (int i = 0; i < 4; i++) step(1, 1, 0, $urandom, 0);
    check("stall_full", 64'(max_cnt_seen), 64'h1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, $urandom, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);

    // Full queue plus flush in the same cycle.
    step(1, 1, 0, $urandom, 0);
    step(1, 1, 0, $urandom, 0);
    check("pre_flush_count", 64'(count_o), 64'(DEPTH));
    step(1, 1, 1, 32'hDEAD_BEEF, 32'h0000_0100);
    check("flush_count", 64'(count_o), 64'h0);
    check("flush_valid", 64'(id_valid_o), 64'h0);
    step(0, 0, 0, 32'h0, 0);

    // pc+4 wraps past the top of the address space.
    pc = 32'hFFFF_FFFC;
    step(1, 1, 0, 32'h1234_5678, 0);
    check("wrap_pc4", 64'(id_pc4_o), 64'h0);
    step(0, 0, 0, 32'h0, 0);

    // Asynchronous reset mid-cycle with two entries queued.
    step(1, 1, 0, $urandom, 0);
    step(1, 1, 0, $urandom, 0);
    check("pre_rst_count", 64'(count_o), 64'(DEPTH));
    start_i = 1'b0; stall_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_count", 64'(count_o), 64'h0);
    check("async_rst_valid", 64'(id_valid_o), 64'h0);
    #1 rst_i = 1'b1;
    sb.delete();
    @(negedge clk_i);
    step(0, 0, 0, 32'h0, 0);

    // start_i low: the queued entry drains and nothing new enters.
    step(1, 1, 0, 32'h0BAD_F00D, 0);
    step(0, 0, 0, 32'h1111_1111, 0);
    step(0, 0, 0, 32'h2222_2222, 0);
    check("nostart_count", 64'(count_o), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0), $urandom, {$urandom, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
